// File: rtl/common_pkg.sv
// Shared helpers for the multi-lane queue: leading-ones count
// and default pointer/count widths.
package common_pkg;

    localparam int DEF_DEPTH = 8;
    localparam int DEF_PTR_W = $clog2(DEF_DEPTH);
    localparam int DEF_CNT_W = DEF_PTR_W + 1;

    // Number of consecutive ones starting at bit 0, within the low w bits.
    function automatic int lead_ones(input logic [63:0] v, input int w);
        int   n;
        logic run;
        n   = 0;
        run = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (i >= w || !v[i]) run = 1'b0;
            if (run) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/lead_ones_cnt.sv
// Counts consecutive ones from bit 0 of a lane handshake vector.
module lead_ones_cnt
    import common_pkg::*;
#(
    parameter int W  = 2,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  vec,
    output logic [CW-1:0] cnt
);

    assign cnt = CW'(lead_ones(64'(vec), W));

endmodule

// File: rtl/multi_lane_fifo.sv
// In-order circular FIFO with thermometer multi-lane enqueue/dequeue
// and synchronous flush.
module multi_lane_fifo
    import common_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ENQ_W  = 2,
    parameter int DEQ_W  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [ENQ_W-1:0]              enq_valid,
    input  logic [ENQ_W-1:0][DATA_W-1:0]  enq_data,
    output logic [ENQ_W-1:0]              enq_ready,
    output logic [DEQ_W-1:0]              deq_valid,
    output logic [DEQ_W-1:0][DATA_W-1:0]  deq_data,
    input  logic [DEQ_W-1:0]              deq_ready,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          full,
    output logic                          empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NE_W  = $clog2(ENQ_W + 1);
    localparam int ND_W  = $clog2(DEQ_W + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  free;
    logic [NE_W-1:0]   n_enq;
    logic [ND_W-1:0]   n_deq;
    logic              clr;

    assign clr  = rst | flush;
    assign free = CNT_W'(DEPTH) - count;

    // Handshakes depend on registered count only; dequeues never free
    // space in the same cycle.
    always_comb begin
        for (int i = 0; i < ENQ_W; i++) begin
            enq_ready[i] = free > CNT_W'(i);
        end
        for (int i = 0; i < DEQ_W; i++) begin
            deq_valid[i] = count > CNT_W'(i);
            deq_data[i]  = mem[head + PTR_W'(i)];
        end
    end

    assign full  = count == CNT_W'(DEPTH);
    assign empty = count == '0;

    lead_ones_cnt #(.W(ENQ_W), .CW(NE_W)) u_enq_cnt (
        .vec (enq_valid & enq_ready),
        .cnt (n_enq)
    );

    lead_ones_cnt #(.W(DEQ_W), .CW(ND_W)) u_deq_cnt (
        .vec (deq_valid & deq_ready),
        .cnt (n_deq)
    );

    always_ff @(posedge clk) begin
        if (!clr) begin
            for (int i = 0; i < ENQ_W; i++) begin
                if (i < int'(n_enq)) mem[tail + PTR_W'(i)] <= enq_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(n_deq);
            tail  <= tail + PTR_W'(n_enq);
            count <= count + CNT_W'(n_enq) - CNT_W'(n_deq);
        end
    end

    logic [ENQ_W-1:0] ev_inc;
    assign ev_inc = enq_valid + ENQ_W'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count <= CNT_W'(DEPTH))
                else $error("count exceeds DEPTH: %0d", count);
            assert ((enq_valid & ev_inc) == '0)
                else $warning("enq_valid not thermometer: %b", enq_valid);
        end
    end

endmodule

// File: tb/tb_multi_lane_fifo.sv
// Scoreboard bench for multi_lane_fifo (DEPTH=8, 2x2 lanes).
module tb_multi_lane_fifo;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [1:0]       enq_valid;
    logic [1:0][31:0] enq_data;
    logic [1:0]       enq_ready;
    logic [1:0]       deq_valid;
    logic [1:0][31:0] deq_data;
    logic [1:0]       deq_ready;
    logic [3:0]       count;
    logic             full;
    logic             empty;

    int          nchk  = 0;
    int          nfail = 0;
    logic [31:0] m_q[$];

    multi_lane_fifo #(
        .DATA_W (32),
        .DEPTH  (8),
        .ENQ_W  (2),
        .DEQ_W  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_data  (enq_data),
        .enq_ready (enq_ready),
        .deq_valid (deq_valid),
        .deq_data  (deq_data),
        .deq_ready (deq_ready),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    // Drive one cycle and advance the reference queue by the accepted
    // enqueue/dequeue counts implied by the current occupancy.
    task automatic drive(input logic [1:0] ev, input logic [31:0] d0,
                         input logic [31:0] d1, input logic [1:0] dr,
                         input logic fl, input logic rs);
        int   sz;
        int   ne;
        int   nd;
        logic run;
        logic [31:0] dv [2];
        enq_valid = ev;
        enq_data  = {d1, d0};
        deq_ready = dr;
        flush     = fl;
        rst       = rs;
        sz  = m_q.size();
        dv[0] = d0;
        dv[1] = d1;
        ne  = 0;
        run = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (!(ev[i] && (8 - sz) > i)) run = 1'b0;
            if (run) ne++;
        end
        nd  = 0;
        run = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (!(dr[i] && sz > i)) run = 1'b0;
            if (run) nd++;
        end
        if (rs || fl) begin
            m_q.delete();
        end else begin
            for (int i = 0; i < nd; i++) void'(m_q.pop_front());
            for (int i = 0; i < ne; i++) m_q.push_back(dv[i]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_drain();
        int guard;
        guard = 0;
        while (m_q.size() > 0 && guard < 20) begin
            nchk++;
            if (deq_valid !== (m_q.size() >= 2 ? 2'b11 : 2'b01)) begin
                nfail++;
                $display("FAIL drain_valid: got %b want size %0d",
                         deq_valid, m_q.size());
            end
            nchk++;
            if (deq_data[0] !== m_q[0]) begin
                nfail++;
                $display("FAIL drain_lane0: got %h want %h",
                         deq_data[0], m_q[0]);
            end
            if (m_q.size() > 1) begin
                nchk++;
                if (deq_data[1] !== m_q[1]) begin
                    nfail++;
                    $display("FAIL drain_lane1: got %h want %h",
                             deq_data[1], m_q[1]);
                end
            end
            drive(2'b00, 0, 0, 2'b11, 1'b0, 1'b0);
            guard++;
        end
        nchk++;
        if (count !== 4'd0 || empty !== 1'b1) begin
            nfail++;
            $display("FAIL drain_empty: count %0d empty %b want 0 1",
                     count, empty);
        end
    endtask

    task automatic test_reset();
        drive(2'b11, 32'hdead, 32'hbeef, 2'b11, 1'b0, 1'b1);
        drive(2'b00, 0, 0, 2'b00, 1'b0, 1'b1);
        drive(2'b00, 0, 0, 2'b00, 1'b0, 1'b0);
        nchk++;
        if (count !== 4'd0) begin
            nfail++; $display("FAIL rst_count: got %0d want 0", count);
        end
        nchk++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            nfail++; $display("FAIL rst_flags: empty %b full %b want 1 0", empty, full);
        end
        nchk++;
        if (deq_valid !== 2'b00) begin
            nfail++; $display("FAIL rst_deq_valid: got %b want 00", deq_valid);
        end
        nchk++;
        if (enq_ready !== 2'b11) begin
            nfail++; $display("FAIL rst_enq_ready: got %b want 11", enq_ready);
        end
    endtask

    task automatic test_fill();
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 32'(2*k+1), 32'(2*k+2), 2'b00, 1'b0, 1'b0);
            nchk++;
            if (count !== 4'(2*(k+1))) begin
                nfail++;
                $display("FAIL fill_count: got %0d want %0d", count, 2*(k+1));
            end
        end
        nchk++;
        if (full !== 1'b1 || enq_ready !== 2'b00) begin
            nfail++; $display("FAIL fill_full: full %b rdy %b want 1 00", full, enq_ready);
        end
        nchk++;
        if (deq_valid !== 2'b11) begin
            nfail++; $display("FAIL fill_deq_valid: got %b want 11", deq_valid);
        end
        nchk++;
        if (deq_data[0] !== 32'd1 || deq_data[1] !== 32'd2) begin
            nfail++;
            $display("FAIL fill_head: got %0d,%0d want 1,2", deq_data[0], deq_data[1]);
        end
    endtask

    task automatic test_full_simul();
        drive(2'b11, 32'd9, 32'd10, 2'b11, 1'b0, 1'b0);
        nchk++;
        if (count !== 4'd6) begin
            nfail++; $display("FAIL fullsim_count: got %0d want 6", count);
        end
        nchk++;
        if (deq_data[0] !== 32'd3 || deq_data[1] !== 32'd4) begin
            nfail++;
            $display("FAIL fullsim_head: got %0d,%0d want 3,4", deq_data[0], deq_data[1]);
        end
    endtask

    task automatic test_partial();
        drive(2'b01, 32'd11, 32'd0, 2'b00, 1'b0, 1'b0);
        nchk++;
        if (count !== 4'd7 || enq_ready !== 2'b01) begin
            nfail++;
            $display("FAIL partial_ready: count %0d rdy %b want 7 01", count, enq_ready);
        end
        drive(2'b11, 32'hA, 32'hB, 2'b00, 1'b0, 1'b0);
        nchk++;
        if (count !== 4'd8) begin
            nfail++; $display("FAIL partial_count: got %0d want 8", count);
        end
        nchk++;
        if (m_q[7] !== 32'hA) begin
            nfail++; $display("FAIL partial_model: got %h want a", m_q[7]);
        end
        test_drain();
    endtask

    task automatic test_gap();
        drive(2'b10, 32'h77, 32'h78, 2'b00, 1'b0, 1'b0);
        nchk++;
        if (count !== 4'd0) begin
            nfail++; $display("FAIL gap_enq: got %0d want 0", count);
        end
        drive(2'b11, 32'h20, 32'h21, 2'b00, 1'b0, 1'b0);
        drive(2'b01, 32'h22, 32'h0, 2'b00, 1'b0, 1'b0);
        drive(2'b00, 0, 0, 2'b10, 1'b0, 1'b0);
        nchk++;
        if (count !== 4'd3) begin
            nfail++; $display("FAIL gap_deq: got %0d want 3", count);
        end
        test_drain();
    endtask

    task automatic test_wrap();
        logic [31:0] nxt;
        logic [31:0] din;
        nxt = 0;
        din = 2;
        drive(2'b11, 32'd0, 32'd1, 2'b11, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            nchk++;
            if (deq_valid !== 2'b11 || count !== 4'd2) begin
                nfail++;
                $display("FAIL wrap_state: vld %b count %0d want 11 2", deq_valid, count);
            end
            nchk++;
            if (deq_data[0] !== nxt || deq_data[1] !== nxt + 1) begin
                nfail++;
                $display("FAIL wrap_order: got %0d,%0d want %0d,%0d",
                         deq_data[0], deq_data[1], nxt, nxt + 1);
            end
            drive(2'b11, din, din + 1, 2'b11, 1'b0, 1'b0);
            nxt = nxt + 2;
            din = din + 2;
        end
        test_drain();
    endtask

    task automatic test_flush();
        for (int r = 0; r < 2; r++) begin
            drive(2'b11, 32'h30, 32'h31, 2'b00, 1'b0, 1'b0);
            drive(2'b11, 32'h32, 32'h33, 2'b00, 1'b0, 1'b0);
            drive(2'b01, 32'h34, 32'h0, 2'b00, 1'b0, 1'b0);
            nchk++;
            if (count !== 4'd5) begin
                nfail++; $display("FAIL flush_pre: got %0d want 5", count);
            end
            drive(2'b11, 32'h40, 32'h41, 2'b11, r == 0, r == 1);
            nchk++;
            if (count !== 4'd0 || empty !== 1'b1 || deq_valid !== 2'b00) begin
                nfail++;
                $display("FAIL flush_clear%0d: count %0d empty %b vld %b want 0 1 00",
                         r, count, empty, deq_valid);
            end
        end
        drive(2'b01, 32'h55, 32'h0, 2'b00, 1'b0, 1'b0);
        nchk++;
        if (deq_valid !== 2'b01 || deq_data[0] !== 32'h55) begin
            nfail++;
            $display("FAIL flush_post: vld %b data %h want 01 55", deq_valid, deq_data[0]);
        end
        test_drain();
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        enq_valid = '0;
        enq_data  = '0;
        deq_ready = '0;
        test_reset();
        test_fill();
        test_full_simul();
        test_partial();
        test_gap();
        test_wrap();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
